ecall_halt_controller: RTL
==========================

Name: ecall_halt_controller

Overview:
- Sequences ECALL handling in the 5-stage pipeline.
- When the ID-stage instruction is ECALL, it resolves the current x17 value using the same priority as the forwarding unit, stalling while that value is not yet available.
- It then either retires the ECALL as a no-op, or halts fetch, drains the older instructions and raises is_halted.
- It sits beside the hazard detection unit and ORs its stall/flush requests into the pipeline-register controls.

Parameters:
- HALT_CODE, 10: x17 value that requests halt.
- DRAIN_CYCLES, 3: cycles after the halt decision until is_halted (ECALL passes EX, MEM, WB).
- ECALL_REG, 17: register index checked.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- id_is_ecall  input  1  IF/ID instruction is ECALL and valid
- id_ex_reg_write  input  1  ID/EX instruction writes rd
- id_ex_rd  input  5  ID/EX destination
- ex_mem_reg_write  input  1  EX/MEM writes rd
- ex_mem_mem_read  input  1  EX/MEM is a load
- ex_mem_rd  input  5  EX/MEM destination
- ex_mem_alu_out  input  32  EX/MEM ALU result
- mem_wb_reg_write  input  1  MEM/WB writes rd
- mem_wb_rd  input  5  MEM/WB destination
- mem_wb_value  input  32  MEM/WB writeback data
- rf_x17  input  32  register-file read of x17
- ecall_stall  output  1  hold PC and IF/ID, bubble into ID/EX
- fetch_halt  output  1  stop PC update, flush IF/ID
- is_halted  output  1  sticky halt indication
- ecall_count  output  16  ECALLs retired as no-op (saturating)

Behaviour:
- Reset (sync, clk edge with reset=1):
  - state=IDLE, drain counter=0, ecall_count=0.
  - All outputs are 0 from the following cycle.
  - Reset dominates every other input in any state, including mid-DRAIN and HALTED.
- Resolution function (combinational, used in IDLE and WAIT):
  - hazard = id_ex_reg_write && id_ex_rd==ECALL_REG, or ex_mem_reg_write && ex_mem_mem_read && ex_mem_rd==ECALL_REG.
  - If there is no hazard, the value is chosen by priority:
    1. ex_mem_alu_out, if ex_mem_reg_write && ex_mem_rd==ECALL_REG && !ex_mem_mem_read.
    2. mem_wb_value, if mem_wb_reg_write && mem_wb_rd==ECALL_REG.
    3. rf_x17 otherwise.
  - Comparison is a full 32-bit equality against HALT_CODE.
- States:
  - IDLE:
    - id_is_ecall=0: stay; outputs 0.
    - id_is_ecall && hazard: ecall_stall=1 combinationally in the same cycle; next state WAIT.
    - id_is_ecall && !hazard && value==HALT_CODE: fetch_halt=1 in the same cycle; next state DRAIN, counter loaded with DRAIN_CYCLES-1.
    - id_is_ecall && !hazard && value!=HALT_CODE: no stall; ecall_count increments (saturating at 0xFFFF); stay in IDLE. The ECALL proceeds as a no-op.
  - WAIT:
    - ecall_stall=1 while hazard persists.
    - When hazard clears, apply the same decision as IDLE in that cycle: ecall_stall=0, then go to DRAIN or IDLE.
    - If id_is_ecall drops (external flush, e.g. branch mispredict), return to IDLE with no count change.
  - DRAIN:
    - fetch_halt=1 and ecall_stall=0; id_is_ecall is ignored.
    - Counter decrements each cycle; at 0, next state HALTED.
  - HALTED:
    - fetch_halt=1, is_halted=1; held until reset.
- Timing:
  - ecall_stall and fetch_halt are Mealy outputs in IDLE/WAIT.
  - is_halted is registered: it rises exactly DRAIN_CYCLES cycles after the decision cycle.
- Boundary conditions:
  - ECALL_REG is never 0, so no x0 special case is needed.
  - Back-to-back ECALLs in IDLE each decide independently, one per cycle.
  - A halt decision takes priority over the count increment.
  - ecall_count is unchanged in DRAIN and HALTED.

Test Plan:
- Reset then idle: outputs all 0, ecall_count=0 → remains 0 over 10 cycles with id_is_ecall=0.
- ECALL with rf_x17=10 and no writers → fetch_halt=1 in cycle 0; is_halted=1 at cycle 3 and stays high for 20 cycles; ecall_count=0.
- ECALL, ID/EX writes x17, next cycle EX/MEM non-load with ex_mem_alu_out=10 → ecall_stall=1 for exactly 1 cycle, then halt sequence starts.
- ECALL with EX/MEM load to x17 (stall 1 cycle), then MEM/WB value=5 while rf_x17=10 → no halt; ecall_count=1 (MEM/WB beats the register file).
- ECALL during a WAIT stall with id_is_ecall dropped → return to IDLE; ecall_stall=0 next cycle; count unchanged.
- Reset asserted in DRAIN (counter=1) → next cycle is_halted=0, fetch_halt=0, state IDLE; a subsequent ECALL with x17=10 halts normally.

Source files
------------

// File: rtl/ecall_halt_if.sv
// Pipeline-side signal bundle for the ECALL halt controller.
// It carries the ID-stage ECALL flag, the x17 forwarding sources, and the stall, halt and count results.
interface ecall_halt_if;
  logic        id_is_ecall;
  logic        id_ex_reg_write;
  logic [4:0]  id_ex_rd;
  logic        ex_mem_reg_write;
  logic        ex_mem_mem_read;
  logic [4:0]  ex_mem_rd;
  logic [31:0] ex_mem_alu_out;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_value;
  logic [31:0] rf_x17;
  logic        ecall_stall;
  logic        fetch_halt;
  logic        is_halted;
  logic [15:0] ecall_count;

  modport master (
    output id_is_ecall, id_ex_reg_write, id_ex_rd, ex_mem_reg_write, ex_mem_mem_read,
           ex_mem_rd, ex_mem_alu_out, mem_wb_reg_write, mem_wb_rd, mem_wb_value, rf_x17,
    input  ecall_stall, fetch_halt, is_halted, ecall_count
  );

  modport slave (
    input  id_is_ecall, id_ex_reg_write, id_ex_rd, ex_mem_reg_write, ex_mem_mem_read,
           ex_mem_rd, ex_mem_alu_out, mem_wb_reg_write, mem_wb_rd, mem_wb_value, rf_x17,
    output ecall_stall, fetch_halt, is_halted, ecall_count
  );
endinterface

// File: rtl/ecall_halt_controller.sv
// ECALL sequencer: resolves x17 with forwarding priority, then either retires the ECALL
// as a counted no-op or halts fetch, drains the older instructions and latches is_halted.
//   state  | meaning
//   IDLE   | no ECALL pending; decides immediately when x17 is resolvable
//   WAIT   | ECALL stalled in ID until x17 producer reaches a forwardable stage
//   DRAIN  | fetch halted, older instructions retiring
//   HALTED | sticky halt until reset
module ecall_halt_controller #(
  parameter logic [31:0] HALT_CODE    = 32'd10,
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [4:0]  ECALL_REG    = 5'd17
) (
  input logic        clk,
  input logic        reset,
  ecall_halt_if.slave bus
);
  localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, HALTED} state_t;

  state_t      state;
  logic [CW-1:0] drain_cnt;
  logic [15:0] count;
  logic        halted;

  logic        hazard;
  logic [31:0] x17_value;
  logic        deciding;
  logic        halt_req;

  always_comb begin
    hazard = (bus.id_ex_reg_write && bus.id_ex_rd == ECALL_REG) ||
             (bus.ex_mem_reg_write && bus.ex_mem_mem_read && bus.ex_mem_rd == ECALL_REG);
    if (bus.ex_mem_reg_write && !bus.ex_mem_mem_read && bus.ex_mem_rd == ECALL_REG)
      x17_value = bus.ex_mem_alu_out;
    else if (bus.mem_wb_reg_write && bus.mem_wb_rd == ECALL_REG)
      x17_value = bus.mem_wb_value;
    else
      x17_value = bus.rf_x17;
    deciding = (state == IDLE || state == WAIT) && bus.id_is_ecall;
    halt_req = deciding && !hazard && (x17_value == HALT_CODE);
  end

  assign bus.ecall_stall = deciding && hazard;
  assign bus.fetch_halt  = (state == DRAIN) || (state == HALTED) || halt_req;
  assign bus.is_halted   = halted;
  assign bus.ecall_count = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
      count     <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        IDLE, WAIT: begin
          if (!deciding) begin
            state <= IDLE;
          end else if (hazard) begin
            state <= WAIT;
          end else if (halt_req) begin
            // A one-cycle drain means the decision edge itself lands in HALTED.
            if (DRAIN_CYCLES <= 1) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end else begin
            state <= IDLE;
            if (count != 16'hFFFF) count <= count + 16'd1;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - CW'(1);
          if (drain_cnt <= CW'(1)) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
